// File: rtl/packet_scheduler.sv
// Data-island packet arbiter: index priority, age promotion, once-per-field sources.
// Optional statistics counters are built when PACKET_SCHEDULER_STATS_EN is defined.
module packet_scheduler #(
  parameter int                     NUM_SOURCES         = 4,
  parameter logic [NUM_SOURCES-1:0] ONCE_PER_FIELD_MASK = '0,
  parameter int                     AGE_LIMIT           = 8,
  parameter int                     STAT_WIDTH          = 16
) (
  input  logic                              clk_pixel,
  input  logic                              rst_n,
  input  logic                              video_field_end,
  input  logic                              packet_enable,
  input  logic [4:0]                        packet_pixel_counter,
  input  logic [NUM_SOURCES-1:0]            req,
  input  logic [NUM_SOURCES*24-1:0]         src_header,
  input  logic [NUM_SOURCES*224-1:0]        src_sub,
  output logic [23:0]                       header,
  output logic [223:0]                      sub,
  output logic [3:0]                        selected,
  output logic                              selected_valid,
  output logic [NUM_SOURCES-1:0]            ack,
  output logic [NUM_SOURCES*STAT_WIDTH-1:0] sent_count,
  output logic [STAT_WIDTH-1:0]             null_count
);

  localparam int AW = $clog2(AGE_LIMIT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

  logic [NUM_SOURCES-1:0] sent_flag;
  logic [AW-1:0]          age [NUM_SOURCES];

  logic [NUM_SOURCES-1:0] elig;
  logic [NUM_SOURCES-1:0] promo;
  logic [NUM_SOURCES-1:0] win_oh;
  logic                   win_found;
  logic [3:0]             win_idx;
  logic [23:0]            hdr_mux;
  logic [223:0]           sub_mux;

  // A coincident field end clears the flags before arbitration sees them.
  always_comb begin
    elig      = '0;
    promo     = '0;
    win_oh    = '0;
    win_found = 1'b0;
    win_idx   = '0;
    hdr_mux   = '0;
    sub_mux   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (ONCE_PER_FIELD_MASK[i]) begin
        elig[i] = !sent_flag[i] || video_field_end;
      end else begin
        elig[i]  = req[i];
        promo[i] = req[i] && (age[i] == AGE_MAX);
      end
    end
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_found = 1'b1;
        win_idx   = 4'(i);
      end
    end
    if (|promo) begin
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
        if (promo[i]) win_idx = 4'(i);
      end
    end
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (win_found && (win_idx == 4'(i))) begin
        win_oh[i] = 1'b1;
        hdr_mux   = src_header[24*i +: 24];
        sub_mux   = src_sub[224*i +: 224];
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      header         <= '0;
      sub            <= '0;
      selected       <= '0;
      selected_valid <= 1'b0;
      ack            <= '0;
      sent_flag      <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) age[i] <= '0;
    end else begin
      ack <= '0;
      if (video_field_end && !packet_enable) sent_flag <= '0;
      if (packet_enable) begin
        header         <= hdr_mux;
        sub            <= sub_mux;
        selected       <= win_found ? win_idx : 4'd0;
        selected_valid <= win_found;
        ack            <= win_oh;
        sent_flag      <= (video_field_end ? '0 : sent_flag)
                        | (win_oh & ONCE_PER_FIELD_MASK);
        for (int i = 0; i < NUM_SOURCES; i++) begin
          if (!ONCE_PER_FIELD_MASK[i]) begin
            if (win_oh[i] || !req[i]) age[i] <= '0;
            else if (age[i] != AGE_MAX) age[i] <= age[i] + AW'(1);
          end
        end
      end
    end
  end

`ifdef PACKET_SCHEDULER_STATS_EN
  logic [STAT_WIDTH-1:0] sent_cnt [NUM_SOURCES];
  logic [STAT_WIDTH-1:0] null_cnt;

  // Counts the slot just finishing, so a new decision in the same cycle suppresses it.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      null_cnt <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) sent_cnt[i] <= '0;
    end else if (packet_pixel_counter == 5'd31 && !packet_enable) begin
      if (selected_valid) begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
          if (selected == 4'(i) && sent_cnt[i] != '1)
            sent_cnt[i] <= sent_cnt[i] + 1'b1;
        end
      end else if (null_cnt != '1) begin
        null_cnt <= null_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_cnt
    assign sent_count[g*STAT_WIDTH +: STAT_WIDTH] = sent_cnt[g];
  end
  assign null_count = null_cnt;
`else
  logic unused_ppc;
  assign unused_ppc = ^packet_pixel_counter;
  assign sent_count = '0;
  assign null_count = '0;
`endif

endmodule

// File: tb/tb_packet_scheduler.sv
// Bench for packet_scheduler: directed vector table plus randomized run
// against a queue-free behavioural model of the arbitration rules.
module tb_packet_scheduler;

  localparam int N  = 4;
  localparam int AL = 2;
  localparam int SW = 2;
  localparam logic [N-1:0] MASK = 4'b1000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            vfe;
  logic            pe;
  logic [4:0]      ppc;
  logic [N-1:0]    req;
  logic [N*24-1:0] src_header;
  logic [N*224-1:0] src_sub;
  logic [23:0]     header;
  logic [223:0]    sub;
  logic [3:0]      selected;
  logic            selected_valid;
  logic [N-1:0]    ack;
  logic [N*SW-1:0] sent_count;
  logic [SW-1:0]   null_count;

  int checks = 0;
  int errors = 0;

  packet_scheduler #(
    .NUM_SOURCES(N), .ONCE_PER_FIELD_MASK(MASK),
    .AGE_LIMIT(AL), .STAT_WIDTH(SW)
  ) dut (
    .clk_pixel(clk), .rst_n(rst_n), .video_field_end(vfe),
    .packet_enable(pe), .packet_pixel_counter(ppc), .req(req),
    .src_header(src_header), .src_sub(src_sub), .header(header),
    .sub(sub), .selected(selected), .selected_valid(selected_valid),
    .ack(ack), .sent_count(sent_count), .null_count(null_count)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [23:0]  m_hdr;
  logic [223:0] m_sub;
  int           m_sel;
  bit           m_vld;
  logic [N-1:0] m_ack;
  bit           m_flag [N];
  int           m_age  [N];
  int           m_sent [N];
  int           m_null;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(bit r, bit p, bit v, int pc, logic [N-1:0] rq,
                            logic [N*24-1:0] h, logic [N*224-1:0] s);
    int win;
    int cap;
    cap = (1 << SW) - 1;
    if (!r) begin
      m_hdr = '0; m_sub = '0; m_sel = 0; m_vld = 0; m_ack = '0; m_null = 0;
      for (int i = 0; i < N; i++) begin
        m_flag[i] = 0; m_age[i] = 0; m_sent[i] = 0;
      end
      return;
    end
`ifdef PACKET_SCHEDULER_STATS_EN
    if (pc == 31 && !p) begin
      if (m_vld) m_sent[m_sel] = (m_sent[m_sel] < cap) ? m_sent[m_sel] + 1 : cap;
      else m_null = (m_null < cap) ? m_null + 1 : cap;
    end
`endif
    m_ack = '0;
    if (v) for (int i = 0; i < N; i++) m_flag[i] = 0;
    if (!p) return;
    win = -1;
    for (int i = 0; i < N; i++)
      if (win < 0 && !MASK[i] && rq[i] && m_age[i] == AL) win = i;
    for (int i = 0; i < N; i++)
      if (win < 0 && (MASK[i] ? !m_flag[i] : rq[i])) win = i;
    for (int i = 0; i < N; i++) begin
      if (MASK[i]) continue;
      if (i == win || !rq[i]) m_age[i] = 0;
      else if (m_age[i] < AL) m_age[i]++;
    end
    if (win < 0) begin
      m_hdr = '0; m_sub = '0; m_sel = 0; m_vld = 0;
    end else begin
      m_hdr = h[24*win +: 24];
      m_sub = s[224*win +: 224];
      m_sel = win; m_vld = 1;
      m_ack[win] = 1'b1;
      if (MASK[win]) m_flag[win] = 1;
    end
  endtask

  task automatic tick();
    bit r, p, v;
    int pc;
    logic [N-1:0] rq;
    logic [N*24-1:0] h;
    logic [N*224-1:0] s;
    logic [N*SW-1:0] esc;
    r = rst_n; p = pe; v = vfe; pc = ppc; rq = req; h = src_header; s = src_sub;
    @(posedge clk);
    #1;
    model_step(r, p, v, pc, rq, h, s);
    for (int i = 0; i < N; i++) esc[SW*i +: SW] = SW'(m_sent[i]);
    chk("header", header, m_hdr);
    chk("sub", sub, m_sub);
    chk("selected", selected, 4'(m_sel));
    chk("selected_valid", selected_valid, m_vld);
    chk("ack", ack, m_ack);
    chk("sent_count", sent_count, esc);
    chk("null_count", null_count, SW'(m_null));
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) src_header[24*i +: 24] = 24'($urandom);
    for (int w = 0; w < N*7; w++) src_sub[32*w +: 32] = $urandom;
  endtask

  typedef struct {
    bit         rst_n;
    bit         pe;
    bit         vfe;
    logic [4:0] ppc;
    logic [3:0] req;
    logic [3:0] sel;
    bit         vld;
    logic [3:0] ack;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [SW-1:0] sat_exp;
    tbl[0]  = '{0, 0, 0, 5'd0,  4'b0000, 4'd0, 0, 4'b0000};
    tbl[1]  = '{1, 1, 0, 5'd0,  4'b0110, 4'd1, 1, 4'b0010};
    tbl[2]  = '{1, 1, 0, 5'd0,  4'b0000, 4'd3, 1, 4'b1000};
    tbl[3]  = '{1, 1, 0, 5'd0,  4'b0000, 4'd0, 0, 4'b0000};
    tbl[4]  = '{1, 0, 0, 5'd31, 4'b0000, 4'd0, 0, 4'b0000};
    tbl[5]  = '{1, 1, 1, 5'd0,  4'b0000, 4'd3, 1, 4'b1000};
    tbl[6]  = '{1, 0, 0, 5'd0,  4'b0000, 4'd3, 1, 4'b0000};
    tbl[7]  = '{1, 1, 0, 5'd0,  4'b0011, 4'd0, 1, 4'b0001};
    tbl[8]  = '{1, 1, 0, 5'd0,  4'b0011, 4'd0, 1, 4'b0001};
    tbl[9]  = '{1, 1, 0, 5'd0,  4'b0011, 4'd1, 1, 4'b0010};
    tbl[10] = '{1, 0, 0, 5'd0,  4'b0011, 4'd1, 1, 4'b0000};
    tbl[11] = '{0, 0, 0, 5'd0,  4'b0011, 4'd0, 0, 4'b0000};
    tbl[12] = '{1, 1, 0, 5'd0,  4'b0001, 4'd0, 1, 4'b0001};
    for (int i = 13; i < 18; i++)
      tbl[i] = '{1, 0, 0, 5'd31, 4'b0000, 4'd0, 1, 4'b0000};

    rst_n = 0; pe = 0; vfe = 0; ppc = 0; req = '0;
    randomize_data();
    tick();

    for (int i = 0; i < 18; i++) begin
      rst_n = tbl[i].rst_n; pe = tbl[i].pe; vfe = tbl[i].vfe;
      ppc = tbl[i].ppc; req = tbl[i].req;
      randomize_data();
      tick();
      chk($sformatf("tbl%0d_sel", i), selected, tbl[i].sel);
      chk($sformatf("tbl%0d_vld", i), selected_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_ack", i), ack, tbl[i].ack);
    end
`ifdef PACKET_SCHEDULER_STATS_EN
    sat_exp = 2'd3;
`else
    sat_exp = 2'd0;
`endif
    chk("sent0_saturated", sent_count[SW-1:0], sat_exp);

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      pe    = ($urandom_range(0, 2) == 0);
      vfe   = ($urandom_range(0, 19) == 0);
      ppc   = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
      req   = 4'($urandom);
      randomize_data();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
